color_blob_tracker: RTL and testbench
=====================================

Name: color_blob_tracker

Overview:
- Parametrised successor to the single-colour longest-run tracker in the V_Color_Tracker path.
- Consumes the 1-bit colour-match column (top/middle/bottom taps) from the existing line buffer and applies a 3x3 majority filter with a runtime threshold.
- Each frame it locates the object by one of two modes: longest horizontal run, or bounding box.
- Publishes a registered centre, run length and found flag, plus a one-cycle frame-done pulse.

Parameters:
- H_BITS, 10, width of horizontal index and horizontal results.
- V_BITS, 9, width of vertical index and vertical results.
- MIN_RUN, 4, minimum consecutive filtered pixels for a run to count as an object (mode 0).
- DEFAULT_H, 320, oCenterH value when no object is found.
- DEFAULT_V, 240, oCenterV value when no object is found.

Ports:
- iVgaClk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high reset.
- iTapTop  in  1  colour-match bit, row n-2.
- iTapMiddle  in  1  colour-match bit, row n-1.
- iTapBottom  in  1  colour-match bit, row n.
- iHIndex  in  H_BITS  current column.
- iVIndex  in  V_BITS  current line.
- iVgaHRequest  in  1  high during active pixels of a line.
- iVgaVRequest  in  1  high during the active frame.
- iFilterOn  in  1  1 = majority filter; 0 = pass iTapMiddle.
- iThreshold  in  4  majority threshold; 0 is treated as 1; values above 9 never match.
- iMode  in  1  0 = longest run, 1 = bounding-box centre.
- oIsPixelMask  out  1  filtered mask bit, combinational from window.
- oCenterH  out  H_BITS  object centre column.
- oCenterV  out  V_BITS  object centre line.
- oRunMax  out  H_BITS  longest qualifying run (mode 0); box width (mode 1).
- oObjectFound  out  1  object detected in the last frame.
- oFrameDone  out  1  one-cycle pulse when outputs update.

Behaviour:
- Window:
  - Two delay stages per tap give a 3x3 window; the 4-bit sum covers all 9 bits.
  - oIsPixelMask = (sum >= max(iThreshold,1)) when iFilterOn = 1, else iTapMiddle.
  - The window registers have no reset.
- Reset values:
  - oCenterH = DEFAULT_H, oCenterV = DEFAULT_V.
  - oRunMax = 0, oObjectFound = 0, oFrameDone = 0.
  - All accumulators cleared; state = SYNC.
- States:
  - SYNC: wait for iVgaVRequest = 0 (discards any partial frame after reset), then go to IDLE.
  - IDLE: clear accumulators. When iVgaVRequest = 1, latch iMode into mode_q and go to WAIT_LINE.
  - WAIT_LINE: run counter = 0. If iVgaVRequest = 0, go to FRAME_END (VRequest has priority over HRequest). Else if iVgaHRequest = 1, go to IN_LINE.
  - IN_LINE: if iVgaHRequest = 0, go to WAIT_LINE. Otherwise a mask pixel increments the run counter (saturating at 2^H_BITS-1), and a non-mask pixel clears it.
  - FRAME_END: one cycle; register all outputs, pulse oFrameDone = 1, go to IDLE.
- Mode 0 (longest run):
  - When cntr >= MIN_RUN and cntr > max_run: store max_run = cntr, end_x = iHIndex, line_max = iVIndex.
  - Ties keep the earliest run.
  - At FRAME_END: oCenterH = end_x - (max_run >> 1), oCenterV = line_max, oRunMax = max_run.
- Mode 1 (bounding box):
  - On each mask pixel in IN_LINE, update min_h, max_h, min_v and max_v.
  - The first mask pixel of the frame initialises all four.
  - At FRAME_END: oCenterH = (min_h + max_h) >> 1 and oCenterV = (min_v + max_v) >> 1, each summed at H_BITS+1 / V_BITS+1 bits before the shift.
  - oRunMax = max_h - min_h + 1.
- No object:
  - Applies when no qualifying run (mode 0) or no mask pixel (mode 1) occurred.
  - FRAME_END outputs DEFAULT_H, DEFAULT_V, oRunMax = 0, oObjectFound = 0.
  - oFrameDone still pulses.
- Mode and threshold changes:
  - iMode changes mid-frame take effect at the next IDLE -> WAIT_LINE transition.
  - iThreshold and iFilterOn take effect on the next cycle.
- Hold: outputs hold between oFrameDone pulses.
- Reset mid-frame: outputs return to reset values immediately; the partial frame produces no oFrameDone.
- Latency:
  - oIsPixelMask is 0 cycles after the window registers.
  - Results appear 1 cycle after iVgaVRequest falls while in WAIT_LINE.

Decomposition:
- Package color_tracker_pkg: state encoding (SYNC, IDLE, WAIT_LINE, IN_LINE, FRAME_END), MODE_RUN/MODE_BOX constants, and the 9-pixel window-size constant.
- Sub-module mask_majority_3x3: tap delay registers, 4-bit sum, threshold compare, filter bypass. Outputs oIsPixelMask.
- The tracker FSM and accumulators stay in color_blob_tracker.

Test Plan:
- Reset, then a frame in mode 0, filter off, with a 40-pixel run on line 100 at columns 200-239 -> oFrameDone pulse; oCenterH = 219, oCenterV = 100, oRunMax = 40, oObjectFound = 1.
- Mode 0 with a 3-pixel run only (MIN_RUN = 4) -> oCenterH = 320, oCenterV = 240, oRunMax = 0, oObjectFound = 0, pulse present.
- Mode 1, filter off, mask at columns 100-150 on lines 50-70 -> oCenterH = 125, oCenterV = 60, oRunMax = 51.
- Filter on, threshold 5, isolated single mask pixels plus a 5x5 solid block -> isolated pixels are suppressed; with the block's top-left pixel at column 300, line 200, the 5-pixel run (MIN_RUN = 4) gives oCenterH = 302, oCenterV = 201, oRunMax = 5.
- Toggle iMode mid-frame -> the result uses the mode latched at frame start; the next frame uses the new mode.
- Assert reset mid-frame with a 200-pixel run already counted -> outputs return to defaults; no pulse for that frame; the first full frame after VRequest goes low reports correctly.

Source files
------------

// File: rtl/color_tracker_pkg.sv
// Shared types and constants for the colour blob tracker.
package color_tracker_pkg;

  typedef enum logic [2:0] {
    SYNC,
    IDLE,
    WAIT_LINE,
    IN_LINE,
    FRAME_END
  } trackState_t;

  localparam logic MODE_RUN = 1'b0;
  localparam logic MODE_BOX = 1'b1;

  // Pixels covered by the 3x3 majority window.
  localparam int unsigned WINDOW_SIZE = 9;
  localparam int unsigned SUM_BITS    = $clog2(WINDOW_SIZE + 1);

endpackage

// File: rtl/mask_majority_3x3.sv
// 3x3 majority filter over the colour-match taps, with bypass.
module mask_majority_3x3
  import color_tracker_pkg::*;
(
  input  logic       iVgaClk,
  input  logic       iTapTop,
  input  logic       iTapMiddle,
  input  logic       iTapBottom,
  input  logic       iFilterOn,
  input  logic [3:0] iThreshold,
  output logic       oIsPixelMask
);

  logic [2:0]          colNow;
  logic [2:0]          colD1;
  logic [2:0]          colD2;
  logic [SUM_BITS-1:0] winSum;
  logic [3:0]          threshEff;

  assign colNow = {iTapTop, iTapMiddle, iTapBottom};

  // Two column delay stages form the window; contents need no reset.
  always_ff @(posedge iVgaClk) begin
    colD1 <= colNow;
    colD2 <= colD1;
  end

  // Count set pixels in the window and compare with the effective threshold.
  always_comb begin
    winSum = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      winSum = winSum + SUM_BITS'(colNow[i]) + SUM_BITS'(colD1[i]) + SUM_BITS'(colD2[i]);
    end
    threshEff    = (iThreshold == 4'd0) ? 4'd1 : iThreshold;
    oIsPixelMask = iFilterOn ? (4'(winSum) >= threshEff) : iTapMiddle;
  end

endmodule

// File: rtl/color_blob_tracker.sv
// Per-frame object locator: longest horizontal run or bounding-box centre.
module color_blob_tracker
  import color_tracker_pkg::*;
#(
  parameter int unsigned H_BITS    = 10,
  parameter int unsigned V_BITS    = 9,
  parameter int unsigned MIN_RUN   = 4,
  parameter int unsigned DEFAULT_H = 320,
  parameter int unsigned DEFAULT_V = 240
) (
  input  logic              iVgaClk,
  input  logic              reset,
  input  logic              iTapTop,
  input  logic              iTapMiddle,
  input  logic              iTapBottom,
  input  logic [H_BITS-1:0] iHIndex,
  input  logic [V_BITS-1:0] iVIndex,
  input  logic              iVgaHRequest,
  input  logic              iVgaVRequest,
  input  logic              iFilterOn,
  input  logic [3:0]        iThreshold,
  input  logic              iMode,
  output logic              oIsPixelMask,
  output logic [H_BITS-1:0] oCenterH,
  output logic [V_BITS-1:0] oCenterV,
  output logic [H_BITS-1:0] oRunMax,
  output logic              oObjectFound,
  output logic              oFrameDone
);

  trackState_t state, nextState;

  logic clrAcc, latchMode, clrRun, pixelActive, latchOut;

  logic              modeQ;
  logic [H_BITS-1:0] cntr, cntrNext, maxRun, endX;
  logic [V_BITS-1:0] lineMax;
  logic [H_BITS-1:0] minH, maxH;
  logic [V_BITS-1:0] minV, maxV;
  logic              boxValid;
  logic              runBetter;
  logic [H_BITS:0]   sumH;
  logic [V_BITS:0]   sumV;

  mask_majority_3x3 uMask (
    .iVgaClk     (iVgaClk),
    .iTapTop     (iTapTop),
    .iTapMiddle  (iTapMiddle),
    .iTapBottom  (iTapBottom),
    .iFilterOn   (iFilterOn),
    .iThreshold  (iThreshold),
    .oIsPixelMask(oIsPixelMask)
  );

  // State register.
  always_ff @(posedge iVgaClk or posedge reset) begin
    if (reset) state <= SYNC;
    else       state <= nextState;
  end

  // Next-state logic; end of frame takes priority over a new line.
  always_comb begin
    nextState = state;
    case (state)
      SYNC:      if (!iVgaVRequest) nextState = IDLE;
      IDLE:      if (iVgaVRequest)  nextState = WAIT_LINE;
      WAIT_LINE: begin
        if (!iVgaVRequest)     nextState = FRAME_END;
        else if (iVgaHRequest) nextState = IN_LINE;
      end
      IN_LINE:   if (!iVgaHRequest) nextState = WAIT_LINE;
      FRAME_END: nextState = IDLE;
      default:   nextState = SYNC;
    endcase
  end

  // Control strobes decoded from state.
  always_comb begin
    clrAcc      = (state == IDLE) || (state == SYNC);
    latchMode   = (state == IDLE) && iVgaVRequest;
    clrRun      = (state == WAIT_LINE);
    pixelActive = (state == IN_LINE) && iVgaHRequest;
    latchOut    = (state == WAIT_LINE) && !iVgaVRequest;
    oFrameDone  = (state == FRAME_END);
  end

  // Candidate run length for this pixel and whether it beats the best so far.
  always_comb begin
    cntrNext = '0;
    if (oIsPixelMask) cntrNext = (cntr == '1) ? cntr : cntr + H_BITS'(1);
    runBetter = oIsPixelMask && (cntrNext >= H_BITS'(MIN_RUN)) && (cntrNext > maxRun);
    sumH = {1'b0, minH} + {1'b0, maxH};
    sumV = {1'b0, minV} + {1'b0, maxV};
  end

  // Frame accumulators: run tracking and bounding box.
  always_ff @(posedge iVgaClk or posedge reset) begin
    if (reset) begin
      modeQ    <= MODE_RUN;
      cntr     <= '0;
      maxRun   <= '0;
      endX     <= '0;
      lineMax  <= '0;
      minH     <= '0;
      maxH     <= '0;
      minV     <= '0;
      maxV     <= '0;
      boxValid <= 1'b0;
    end else begin
      if (latchMode) modeQ <= iMode;
      if (clrAcc) begin
        cntr     <= '0;
        maxRun   <= '0;
        endX     <= '0;
        lineMax  <= '0;
        minH     <= '0;
        maxH     <= '0;
        minV     <= '0;
        maxV     <= '0;
        boxValid <= 1'b0;
      end else begin
        if (clrRun) cntr <= '0;
        if (pixelActive) begin
          cntr <= cntrNext;
          if (runBetter) begin
            maxRun  <= cntrNext;
            endX    <= iHIndex;
            lineMax <= iVIndex;
          end
          if (oIsPixelMask) begin
            if (!boxValid) begin
              minH     <= iHIndex;
              maxH     <= iHIndex;
              minV     <= iVIndex;
              maxV     <= iVIndex;
              boxValid <= 1'b1;
            end else begin
              if (iHIndex < minH) minH <= iHIndex;
              if (iHIndex > maxH) maxH <= iHIndex;
              if (iVIndex < minV) minV <= iVIndex;
              if (iVIndex > maxV) maxV <= iVIndex;
            end
          end
        end
      end
    end
  end

  // Result registers, loaded as the frame closes and held otherwise.
  always_ff @(posedge iVgaClk or posedge reset) begin
    if (reset) begin
      oCenterH     <= H_BITS'(DEFAULT_H);
      oCenterV     <= V_BITS'(DEFAULT_V);
      oRunMax      <= '0;
      oObjectFound <= 1'b0;
    end else if (latchOut) begin
      oCenterH     <= H_BITS'(DEFAULT_H);
      oCenterV     <= V_BITS'(DEFAULT_V);
      oRunMax      <= '0;
      oObjectFound <= 1'b0;
      if (modeQ == MODE_RUN) begin
        if (maxRun != '0) begin
          oCenterH     <= endX - (maxRun >> 1);
          oCenterV     <= lineMax;
          oRunMax      <= maxRun;
          oObjectFound <= 1'b1;
        end
      end else if (boxValid) begin
        oCenterH     <= H_BITS'(sumH >> 1);
        oCenterV     <= V_BITS'(sumV >> 1);
        oRunMax      <= maxH - minH + H_BITS'(1);
        oObjectFound <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_color_blob_tracker.sv
// Self-checking bench for color_blob_tracker with a frame-level reference model.
module tb_color_blob_tracker;

  localparam int H_BITS    = 10;
  localparam int V_BITS    = 9;
  localparam int MIN_RUN   = 4;
  localparam int DEFAULT_H = 320;
  localparam int DEFAULT_V = 240;

  logic              iVgaClk = 1'b0;
  logic              reset;
  logic              iTapTop, iTapMiddle, iTapBottom;
  logic [H_BITS-1:0] iHIndex;
  logic [V_BITS-1:0] iVIndex;
  logic              iVgaHRequest, iVgaVRequest;
  logic              iFilterOn;
  logic [3:0]        iThreshold;
  logic              iMode;
  logic              oIsPixelMask;
  logic [H_BITS-1:0] oCenterH;
  logic [V_BITS-1:0] oCenterV;
  logic [H_BITS-1:0] oRunMax;
  logic              oObjectFound;
  logic              oFrameDone;

  color_blob_tracker #(
    .H_BITS   (H_BITS),
    .V_BITS   (V_BITS),
    .MIN_RUN  (MIN_RUN),
    .DEFAULT_H(DEFAULT_H),
    .DEFAULT_V(DEFAULT_V)
  ) dut (
    .iVgaClk     (iVgaClk),
    .reset       (reset),
    .iTapTop     (iTapTop),
    .iTapMiddle  (iTapMiddle),
    .iTapBottom  (iTapBottom),
    .iHIndex     (iHIndex),
    .iVIndex     (iVIndex),
    .iVgaHRequest(iVgaHRequest),
    .iVgaVRequest(iVgaVRequest),
    .iFilterOn   (iFilterOn),
    .iThreshold  (iThreshold),
    .iMode       (iMode),
    .oIsPixelMask(oIsPixelMask),
    .oCenterH    (oCenterH),
    .oCenterV    (oCenterV),
    .oRunMax     (oRunMax),
    .oObjectFound(oObjectFound),
    .oFrameDone  (oFrameDone)
  );

  always #5 iVgaClk = ~iVgaClk;

  int checks = 0;
  int errors = 0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Scene: union of rectangles (single pixels are 1x1 rectangles).
  int rx0[$], rx1[$], ry0[$], ry1[$];

  task automatic clearScene();
    rx0.delete(); rx1.delete(); ry0.delete(); ry1.delete();
  endtask

  task automatic addRect(input int x0, input int x1, input int y0, input int y1);
    rx0.push_back(x0); rx1.push_back(x1); ry0.push_back(y0); ry1.push_back(y1);
  endtask

  function automatic bit img(input int h, input int v);
    for (int i = 0; i < rx0.size(); i++)
      if (h >= rx0[i] && h <= rx1[i] && v >= ry0[i] && v <= ry1[i]) return 1'b1;
    return 1'b0;
  endfunction

  typedef struct {int h; int v; int line; bit m;} pix_t;
  pix_t     recs[$];
  bit [2:0] tapHist[$];
  bit       modelOn = 1'b0;
  int       activeCnt = 0;
  int       lineNo = 0;
  int       expH, expV, expRun, expFound;

  // One pixel clock: drive inputs, check the mask, record what the tracker should see.
  task automatic tick(input int h, input int v, input bit hreq, input bit vreq);
    int       s;
    int       sum;
    int       th;
    bit [2:0] t;
    bit       m;
    s = iFilterOn ? 1 : 0;
    t = '0;
    if (hreq) t = {img(h + s, v - 1), img(h + s, v), img(h + s, v + 1)};
    iHIndex      = h[H_BITS-1:0];
    iVIndex      = v[V_BITS-1:0];
    iVgaHRequest = hreq;
    iVgaVRequest = vreq;
    {iTapTop, iTapMiddle, iTapBottom} = t;
    sum = $countones(t);
    foreach (tapHist[i]) sum += $countones(tapHist[i]);
    th = (iThreshold == 0) ? 1 : int'(iThreshold);
    m  = iFilterOn ? (sum >= th) : t[1];
    #3;
    if (tapHist.size() == 2) checkVal("mask", oIsPixelMask, m);
    if (modelOn && vreq && hreq) begin
      // The cycle on which a line starts is consumed by leaving WAIT_LINE.
      if (activeCnt > 0) recs.push_back('{h, v, lineNo, m});
      activeCnt++;
    end else if (!hreq) begin
      if (activeCnt > 0) lineNo++;
      activeCnt = 0;
    end
    tapHist.push_front(t);
    if (tapHist.size() > 2) void'(tapHist.pop_back());
    @(posedge iVgaClk);
    #1;
  endtask

  function automatic void computeExpected(input bit mode);
    int best, cur, lastLine, ex, ly;
    int minH, maxH, minV, maxV;
    bit any;
    expH = DEFAULT_H; expV = DEFAULT_V; expRun = 0; expFound = 0;
    if (mode == 1'b0) begin
      best = 0; cur = 0; lastLine = -1; ex = 0; ly = 0;
      foreach (recs[i]) begin
        if (recs[i].line != lastLine) cur = 0;
        lastLine = recs[i].line;
        if (recs[i].m) begin
          cur++;
          if (cur >= MIN_RUN && cur > best) begin
            best = cur; ex = recs[i].h; ly = recs[i].v;
          end
        end else cur = 0;
      end
      if (best > 0) begin
        expH = (ex - best / 2) & ((1 << H_BITS) - 1);
        expV = ly; expRun = best; expFound = 1;
      end
    end else begin
      any = 1'b0; minH = 0; maxH = 0; minV = 0; maxV = 0;
      foreach (recs[i]) if (recs[i].m) begin
        if (!any || recs[i].h < minH) minH = recs[i].h;
        if (!any || recs[i].h > maxH) maxH = recs[i].h;
        if (!any || recs[i].v < minV) minV = recs[i].v;
        if (!any || recs[i].v > maxV) maxV = recs[i].v;
        any = 1'b1;
      end
      if (any) begin
        expH = (minH + maxH) / 2; expV = (minV + maxV) / 2;
        expRun = maxH - minH + 1; expFound = 1;
      end
    end
  endfunction

  // Drive one complete frame, then check the frame-end pulse and results.
  task automatic runFrame(input int vs, input int ve, input int hs, input int he, input int toggleV);
    bit frameMode;
    int lat;
    recs.delete(); lineNo = 0; activeCnt = 0; modelOn = 1'b1;
    repeat (3) tick(hs, vs, 0, 0);
    frameMode = iMode;
    repeat (3) tick(hs, vs, 0, 1);
    for (int v = vs; v <= ve; v++) begin
      if (v == toggleV) iMode = ~iMode;
      for (int h = hs; h <= he; h++) tick(h, v, 1, 1);
      repeat (2) tick(he, v, 0, 1);
    end
    tick(0, 0, 0, 1);
    modelOn = 1'b0;
    computeExpected(frameMode);
    tick(0, 0, 0, 0);
    lat = 1;
    while (!oFrameDone && lat < 6) begin
      tick(0, 0, 0, 0);
      lat++;
    end
    checkVal("doneLatency", lat, 1);
    checkVal("centerH", oCenterH, expH);
    checkVal("centerV", oCenterV, expV);
    checkVal("runMax", oRunMax, expRun);
    checkVal("found", oObjectFound, expFound);
    tick(0, 0, 0, 0);
    checkVal("donePulseWidth", oFrameDone, 0);
    checkVal("holdCenterH", oCenterH, expH);
    checkVal("holdRunMax", oRunMax, expRun);
  endtask

  task automatic checkDefaults(input string tag);
    checkVal({tag, "H"}, oCenterH, DEFAULT_H);
    checkVal({tag, "V"}, oCenterV, DEFAULT_V);
    checkVal({tag, "Run"}, oRunMax, 0);
    checkVal({tag, "Found"}, oObjectFound, 0);
    checkVal({tag, "Done"}, oFrameDone, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int seenDone;
    reset = 1'b1;
    iFilterOn = 1'b0; iThreshold = 4'd0; iMode = 1'b0;
    {iTapTop, iTapMiddle, iTapBottom} = '0;
    iHIndex = '0; iVIndex = '0; iVgaHRequest = 1'b0; iVgaVRequest = 1'b0;
    clearScene();
    repeat (3) tick(0, 0, 0, 0);
    checkDefaults("reset");
    reset = 1'b0;
    tick(0, 0, 0, 0);

    // 40-pixel run, mode 0, filter off.
    addRect(200, 239, 100, 100);
    runFrame(99, 101, 190, 250, -1);
    checkVal("run40H", oCenterH, 219);
    checkVal("run40V", oCenterV, 100);
    checkVal("run40Run", oRunMax, 40);

    // 3-pixel run is below the minimum.
    clearScene(); addRect(200, 202, 100, 100);
    runFrame(99, 101, 190, 250, -1);
    checkVal("shortRunFound", oObjectFound, 0);
    checkVal("shortRunH", oCenterH, DEFAULT_H);

    // Bounding box, mode 1.
    clearScene(); addRect(100, 150, 50, 70);
    iMode = 1'b1;
    runFrame(48, 72, 95, 155, -1);
    checkVal("boxH", oCenterH, 125);
    checkVal("boxV", oCenterV, 60);
    checkVal("boxW", oRunMax, 51);

    // Majority filter: isolated pixels suppressed, 5x5 block survives.
    clearScene();
    addRect(300, 304, 200, 204);
    addRect(280, 280, 199, 199);
    addRect(290, 290, 202, 202);
    addRect(320, 320, 206, 206);
    iMode = 1'b0; iFilterOn = 1'b1; iThreshold = 4'd5;
    runFrame(196, 208, 275, 325, -1);
    checkVal("filtH", oCenterH, 302);
    checkVal("filtV", oCenterV, 201);
    checkVal("filtRun", oRunMax, 5);

    // Mode toggled mid-frame: latched mode applies, next frame uses the new one.
    clearScene(); addRect(100, 150, 50, 70);
    iFilterOn = 1'b0; iMode = 1'b0;
    runFrame(48, 72, 95, 155, 60);
    checkVal("toggleV", oCenterV, 50);
    checkVal("toggleRun", oRunMax, 51);
    runFrame(48, 72, 95, 155, -1);
    checkVal("toggleNextV", oCenterV, 60);

    // Reset with a 200-pixel run already counted.
    clearScene(); addRect(10, 209, 30, 30);
    iMode = 1'b0;
    repeat (3) tick(0, 29, 0, 0);
    repeat (3) tick(0, 29, 0, 1);
    for (int v = 29; v <= 30; v++) begin
      for (int h = 0; h <= 220; h++) tick(h, v, 1, 1);
      repeat (2) tick(220, v, 0, 1);
    end
    reset = 1'b1;
    #1;
    checkDefaults("midReset");
    tick(0, 31, 0, 1);
    tick(0, 31, 0, 1);
    reset = 1'b0;
    seenDone = 0;
    for (int v = 31; v <= 32; v++) begin
      for (int h = 0; h <= 220; h++) tick(h, v, 1, 1);
      repeat (2) tick(220, v, 0, 1);
      if (oFrameDone) seenDone++;
    end
    for (int i = 0; i < 6; i++) begin
      tick(0, 0, 0, 0);
      if (oFrameDone) seenDone++;
    end
    checkVal("partialFrameDone", seenDone, 0);
    checkVal("partialFrameH", oCenterH, DEFAULT_H);
    runFrame(29, 31, 0, 220, -1);
    checkVal("afterResetH", oCenterH, 109);
    checkVal("afterResetV", oCenterV, 30);
    checkVal("afterResetRun", oRunMax, 200);

    // Randomized scenes, modes and filter settings.
    for (int f = 0; f < 12; f++) begin
      int n, x0, y0;
      clearScene();
      n = $urandom_range(1, 3);
      for (int r = 0; r < n; r++) begin
        x0 = $urandom_range(20, 68);
        y0 = $urandom_range(10, 22);
        addRect(x0, x0 + $urandom_range(0, 12), y0, y0 + $urandom_range(0, 3));
      end
      n = $urandom_range(0, 3);
      for (int r = 0; r < n; r++) begin
        x0 = $urandom_range(20, 80);
        y0 = $urandom_range(10, 25);
        addRect(x0, x0, y0, y0);
      end
      iMode      = 1'($urandom_range(0, 1));
      iFilterOn  = 1'($urandom_range(0, 1));
      iThreshold = 4'($urandom_range(0, 11));
      runFrame(8, 28, 15, 85, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
